// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter and req/ack instruction fetch stage
module pc_fetch_unit #(
  parameter int PC_WIDTH = 64,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [1:0]          Psel,
  input  logic                step,
  input  logic [PC_WIDTH-1:0] K,
  input  logic [PC_WIDTH-1:0] reg_target,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic [31:0]         imem_rdata,
  input  logic                imem_ack,
  output logic [31:0]         instruction,
  output logic                instr_valid,
  output logic [PC_WIDTH-1:0] pc,
  output logic [PC_WIDTH-1:0] pc_plus4
);
  typedef enum logic [1:0] {FETCH, WAIT, EXEC} state_t;
  state_t state, state_nxt;
  logic accept, retire;
  logic [PC_WIDTH-1:0] pc_nxt;
  localparam logic [PC_WIDTH-1:0] ALIGN = ~PC_WIDTH'(3);
  assign imem_addr = pc;
  assign pc_plus4 = pc + PC_WIDTH'(4);
  // next state, ack acceptance and PC update select; the FETCH cycle right
  // after reset has req low, so a stale ack there is not accepted
  always_comb begin
    accept = imem_ack && (state == WAIT || (state == FETCH && imem_req));
    retire = state == EXEC && step;
    state_nxt = accept ? EXEC : state == FETCH ? WAIT : retire ? FETCH : state;
    pc_nxt = Psel == 2'b01 ? pc_plus4 :
             Psel == 2'b10 ? reg_target & ALIGN :
             Psel == 2'b11 ? pc + (K << 2) : pc;
  end
  // state register
  always_ff @(posedge clock) begin
    if (reset) state <= FETCH;
    else state <= state_nxt;
  end
  // pc, fetched word and request line
  always_ff @(posedge clock) begin
    if (reset) begin
      pc <= RESET_PC;
      instruction <= '0;
      instr_valid <= 1'b0;
      imem_req <= 1'b0;
    end else begin
      if (accept) begin
        instruction <= imem_rdata;
        instr_valid <= 1'b1;
        imem_req <= 1'b0;
      end else if (state == FETCH) imem_req <= 1'b1;
      if (retire) begin
        pc <= pc_nxt;
        instr_valid <= 1'b0;
        imem_req <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: table, directed and random checks against a PC model
module tb_pc_fetch_unit;
  logic clock = 0, reset = 1, step = 0, imem_ack = 0;
  logic [1:0] Psel = 0;
  logic [63:0] K = 0, reg_target = 0;
  logic [31:0] imem_rdata = 0;
  logic imem_req, instr_valid;
  logic [63:0] imem_addr, pc, pc_plus4;
  logic [31:0] instruction;
  int checks = 0, errors = 0;
  logic [63:0] mpc;
  logic [31:0] mw;

  typedef struct {logic [1:0] ps; logic [63:0] k, rt, exp;} vec_t;
  vec_t tbl[9];

  always #5 clock = ~clock;

  pc_fetch_unit #(.PC_WIDTH(64), .RESET_PC(64'd0)) dut (
    .clock(clock), .reset(reset), .Psel(Psel), .step(step), .K(K),
    .reg_target(reg_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ack(imem_ack), .instruction(instruction),
    .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4)
  );

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h", n, a, e);
    end
  endtask

  task automatic fetch(input int dly, input logic [31:0] w, input bit poke);
    int t = 0;
    while (imem_req !== 1'b1 && t < 10) begin
      @(negedge clock);
      t++;
    end
    chk("req_seen", 64'(imem_req), 64'd1);
    chk("fetch_addr", imem_addr, mpc);
    for (int i = 0; i < dly; i++) begin
      step = poke;
      Psel = 2'b01;
      @(negedge clock);
      step = 0;
      chk("req_held", 64'(imem_req), 64'd1);
      chk("addr_held", imem_addr, mpc);
      chk("valid_low_wait", 64'(instr_valid), 64'd0);
    end
    imem_ack = 1;
    imem_rdata = w;
    @(negedge clock);
    imem_ack = 0;
    imem_rdata = $urandom;
    mw = w;
    chk("valid_after_ack", 64'(instr_valid), 64'd1);
    chk("instr_after_ack", 64'(instruction), 64'(w));
    chk("req_after_ack", 64'(imem_req), 64'd0);
    chk("pc_in_exec", pc, mpc);
    chk("pc_plus4", pc_plus4, mpc + 64'd4);
  endtask

  task automatic exec_step(input int hold, input logic [1:0] ps, input logic [63:0] k, input logic [63:0] rt);
    for (int i = 0; i < hold; i++) begin
      imem_rdata = $urandom;
      @(negedge clock);
      chk("instr_stable", 64'(instruction), 64'(mw));
      chk("valid_stable", 64'(instr_valid), 64'd1);
      chk("pc_stable", pc, mpc);
    end
    Psel = ps;
    K = k;
    reg_target = rt;
    step = 1;
    case (ps)
      2'b01: mpc = mpc + 64'd4;
      2'b10: mpc = rt - (rt % 64'd4);
      2'b11: mpc = mpc + k * 64'd4;
      default: ;
    endcase
    @(negedge clock);
    step = 0;
    chk("pc_after_step", pc, mpc);
    chk("valid_after_step", 64'(instr_valid), 64'd0);
    chk("req_after_step", 64'(imem_req), 64'd1);
    chk("addr_after_step", imem_addr, mpc);
  endtask

  initial begin
    tbl[0] = '{2'b10, 64'd0, 64'h40, 64'h40};
    tbl[1] = '{2'b11, -64'sd4, 64'd0, 64'h30};
    tbl[2] = '{2'b10, 64'd0, 64'h40, 64'h40};
    tbl[3] = '{2'b10, 64'd0, 64'h1237, 64'h1234};
    tbl[4] = '{2'b10, 64'd0, 64'h40, 64'h40};
    tbl[5] = '{2'b00, 64'd0, 64'h999, 64'h40};
    tbl[6] = '{2'b10, 64'd0, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFC};
    tbl[7] = '{2'b01, 64'd0, 64'd0, 64'd0};
    tbl[8] = '{2'b11, 64'd3, 64'd0, 64'hC};

    reset = 1;
    repeat (2) @(negedge clock);
    chk("rst_pc", pc, 64'd0);
    chk("rst_valid", 64'(instr_valid), 64'd0);
    chk("rst_req", 64'(imem_req), 64'd0);
    chk("rst_instr", 64'(instruction), 64'd0);
    reset = 0;
    mpc = 0;
    @(negedge clock);
    chk("first_wait_req", 64'(imem_req), 64'd1);
    fetch(0, 32'h91000421, 0);
    exec_step(2, 2'b01, 64'd0, 64'd0);
    fetch(3, 32'h12345678, 0);

    for (int i = 0; i < 9; i++) begin
      exec_step(1, tbl[i].ps, tbl[i].k, tbl[i].rt);
      chk("table_pc", pc, tbl[i].exp);
      mpc = tbl[i].exp;
      fetch(i % 3, 32'hA000_0000 + 32'(i), 1);
    end

    exec_step(0, 2'b10, 64'd0, 64'h80);
    @(negedge clock);
    chk("mid_req", 64'(imem_req), 64'd1);
    chk("mid_addr", imem_addr, 64'h80);
    reset = 1;
    @(negedge clock);
    chk("midrst_pc", pc, 64'd0);
    chk("midrst_valid", 64'(instr_valid), 64'd0);
    chk("midrst_req", 64'(imem_req), 64'd0);
    reset = 0;
    imem_ack = 1;
    imem_rdata = 32'hDEADBEEF;
    @(negedge clock);
    imem_ack = 0;
    chk("stale_ack_valid", 64'(instr_valid), 64'd0);
    chk("stale_ack_req", 64'(imem_req), 64'd1);
    chk("stale_ack_addr", imem_addr, 64'd0);
    mpc = 0;
    fetch(1, 32'h0BAD_F00D, 0);

    for (int i = 0; i < 40; i++) begin
      logic [63:0] k;
      k = $urandom_range(0, 1) ? {$urandom, $urandom} : 64'(int'($urandom_range(0, 64)) - 32);
      exec_step($urandom_range(0, 2), 2'($urandom_range(0, 3)), k, {$urandom, $urandom});
      fetch($urandom_range(0, 3), $urandom, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Program-counter and instruction-fetch stage that sits directly upstream of the per-class instruction decoders. It holds the 64-bit PC and fetches the 32-bit instruction word from instruction memory over a req/ack handshake. It presents that word to the decoders and holds it stable until the control unit signals instruction completion. On completion it updates the PC according to the 2-bit Psel field of the control word.

Parameters:
RESET_PC, 64'd0, PC value loaded on reset; must be a multiple of 4.
PC_WIDTH, 64, width of PC, offset and register-target buses.

Ports:
clock  input  1  system clock; all state changes on the rising edge.
reset  input  1  synchronous, active-high reset.
Psel  input  2  PC update select from the control word: 00 hold, 01 PC+4, 10 register target, 11 PC-relative branch.
step  input  1  one-cycle pulse: current instruction complete (control nextState==00 at final cycle); apply Psel.
K  input  PC_WIDTH  sign-extended word offset for Psel=11.
reg_target  input  PC_WIDTH  register value (A bus) for Psel=10.
imem_req  output  1  fetch request to instruction memory.
imem_addr  output  PC_WIDTH  fetch address; equals pc while imem_req=1.
imem_rdata  input  32  instruction word from memory; valid when imem_ack=1.
imem_ack  input  1  memory response strobe.
instruction  output  32  registered instruction word fed to the decoders.
instr_valid  output  1  instruction holds a fetched word for the current pc.
pc  output  PC_WIDTH  current PC.
pc_plus4  output  PC_WIDTH  pc+4, combinational; the data-bus source when EN_PC is set (BL link).

Behaviour:
- FSM states: FETCH, WAIT, EXEC. Reset enters FETCH.
- Reset values: pc=RESET_PC, instruction=32'd0, instr_valid=0, imem_req=0.
- Reset asserted in any state, including mid-fetch, takes priority over all other inputs. A late imem_ack arriving after reset is ignored unless the FSM is in WAIT.
- FETCH: drive imem_req=1 and imem_addr=pc for one cycle, then go to WAIT.
- WAIT: hold imem_req=1 and imem_addr=pc until imem_ack=1.
  - On the ack edge: instruction<=imem_rdata, instr_valid<=1, imem_req<=0, go to EXEC.
  - Minimum fetch latency: instr_valid rises 2 cycles after leaving reset, with ack in the first WAIT cycle.
  - An ack received in FETCH (same cycle as the first req) is accepted identically and goes straight to EXEC.
- EXEC: instruction and pc are held stable for any number of cycles. When step=1:
  - Psel=00: pc unchanged.
  - Psel=01: pc<=pc+4.
  - Psel=10: pc<={reg_target[PC_WIDTH-1:2],2'b00}.
  - Psel=11: pc<=pc+(K<<2).
  - In every case instr_valid<=0 and the FSM goes to FETCH, so the same address is refetched for Psel=00.
- step outside EXEC is ignored; no PC change and no error.
- Arithmetic is modulo 2^PC_WIDTH. pc+4 and branch targets wrap silently (e.g. pc=64'hFFFF_FFFF_FFFF_FFFC with Psel=01 gives 0). Negative K (two's complement) branches backward.
- pc[1:0] is always 00. Branch targets are word-aligned by construction, and register targets have bits [1:0] cleared.
- imem_rdata is sampled only on an accepted ack. instruction never changes while instr_valid=1.

Test Plan:
- Reset then fetch: assert reset 2 cycles, release, ack in the first WAIT cycle with rdata=32'h91000421 -> imem_addr=0 with req high; instr_valid=1 and instruction=32'h91000421 two cycles after release; pc=0.
- Sequential step: in EXEC at pc=0, step with Psel=01 -> pc=4 the next cycle; instr_valid drops; next fetch presents imem_addr=4; a 3-cycle ack delay keeps req and addr stable throughout.
- Branches: at pc=0x40, Psel=11 with K=-4 -> pc=0x30. At pc=0x40, Psel=10 with reg_target=0x1237 -> pc=0x1234. At pc=0x40, Psel=00 -> refetch of 0x40.
- Wrap: pc=64'hFFFF_FFFF_FFFF_FFFC, Psel=01 -> pc=0, fetch at address 0.
- Ignored step: step pulsed in FETCH/WAIT -> pc unchanged, fetch completes normally.
- Reset mid-fetch: reset during WAIT at pc=0x80 -> pc=RESET_PC, instr_valid=0, imem_req=0 next cycle. A stale ack the cycle after reset (state FETCH) starts no spurious EXEC with the old word; the new fetch targets RESET_PC.
